// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - forwarding select / load-use interlock over an EX..WB destination scoreboard
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard_unit #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int SEL_W   = $clog2(DEPTH+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]  id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic                       id_regwrite,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic [SEL_W-1:0]           id_lat,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
   output logic [31:0]                stall_cnt
);

   logic [DEPTH:1]    sb_valid;
   logic [REG_AW-1:0] sb_rd  [1:DEPTH];
   logic [SEL_W-1:0]  sb_lat [1:DEPTH];

   logic [NUM_SRC*SEL_W-1:0] sel_next;
   logic                     any_haz;
   logic [SEL_W-1:0]         lat_clamped;
   logic                     ins_valid;

   // Youngest producer wins; the WB slot is excluded because the regfile writes before it reads.
   always_comb begin
      logic              found;
      logic [REG_AW-1:0] src;
      sel_next = '0;
      any_haz  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         found = 1'b0;
         src   = id_src[i*REG_AW +: REG_AW];
         for (int k = 1; k < DEPTH; k++) begin
            if (!found && id_src_used[i] && (src != '0) && sb_valid[k] && (sb_rd[k] == src)) begin
               found = 1'b1;
               if (SEL_W'(k) >= sb_lat[k])
                  sel_next[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
               else
                  any_haz = 1'b1;
            end
         end
      end
   end

   assign stall = id_valid & any_haz & ~rst;

   always_comb begin
      lat_clamped = id_lat;
      if (id_lat == '0)
         lat_clamped = SEL_W'(1);
      else if (id_lat > SEL_W'(DEPTH - 1))
         lat_clamped = SEL_W'(DEPTH - 1);
   end

   assign ins_valid = id_valid & ~stall & id_regwrite & (id_rd != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_valid   <= '0;
         ex_fwd_sel <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            sb_rd[k]  <= '0;
            sb_lat[k] <= '0;
         end
      end else if (!hold) begin
         sb_valid[1] <= ins_valid;
         sb_rd[1]    <= id_rd;
         sb_lat[1]   <= lat_clamped;
         for (int k = 2; k <= DEPTH; k++) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_rd[k]    <= sb_rd[k-1];
            sb_lat[k]   <= sb_lat[k-1];
         end
         ex_fwd_sel <= (id_valid && !stall) ? sel_next : '0;
      end
   end

`ifdef FWD_STALL_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (!hold && stall && (cnt_q != 32'hFFFF_FFFF))
         cnt_q <= cnt_q + 32'd1;
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
